// File: rtl/tl_ram_slave.sv
// TileLink-UL slave: terminates Get/PutFull/PutPartial on A with an internal word-wide RAM, replies on D.
// Latency: A handshake in cycle T -> d_valid in cycle T+ACCESS_LAT+1; one transaction at a time.
// Backpressure: a_ready only in IDLE; the D response is held registered and stable until d_ready.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   a_valid/a_ready + a_*       request channel (opcode, param, size, source, address, mask, data)
//   d_valid/d_ready + d_*       response channel (opcode, param, size, source, sink, denied, data)
module tl_ram_slave #(
  parameter int unsigned                TL_ADDR_BITS   = 32,
  parameter int unsigned                TL_DATA_BYTES  = 4,
  parameter int unsigned                TL_SIZE_BITS   = 3,
  parameter int unsigned                TL_SOURCE_BITS = 4,
  parameter int unsigned                TL_SINK_BITS   = 1,
  parameter int unsigned                MEM_WORDS      = 256,
  parameter logic [TL_ADDR_BITS-1:0]    BASE_ADDR      = '0,
  parameter int unsigned                ACCESS_LAT     = 1,
  parameter logic [TL_SINK_BITS-1:0]    SINK_ID        = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  // channel A
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [2:0]                    a_opcode,
  input  logic [2:0]                    a_param,
  input  logic [TL_SIZE_BITS-1:0]       a_size,
  input  logic [TL_SOURCE_BITS-1:0]     a_source,
  input  logic [TL_ADDR_BITS-1:0]       a_address,
  input  logic [TL_DATA_BYTES-1:0]      a_mask,
  input  logic [TL_DATA_BYTES*8-1:0]    a_data,
  // channel D
  output logic                          d_valid,
  input  logic                          d_ready,
  output logic [2:0]                    d_opcode,
  output logic [1:0]                    d_param,
  output logic [TL_SIZE_BITS-1:0]       d_size,
  output logic [TL_SOURCE_BITS-1:0]     d_source,
  output logic [TL_SINK_BITS-1:0]       d_sink,
  output logic                          d_denied,
  output logic [TL_DATA_BYTES*8-1:0]    d_data
);

  localparam int unsigned DATA_W = TL_DATA_BYTES * 8;
  localparam int unsigned OFF_W  = $clog2(TL_DATA_BYTES);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);

  localparam logic [2:0] TL_A_PUTFULL      = 3'd0;
  localparam logic [2:0] TL_A_PUTPARTIAL   = 3'd1;
  localparam logic [2:0] TL_A_GET          = 3'd4;
  localparam logic [2:0] TL_D_ACCESSACK    = 3'd0;
  localparam logic [2:0] TL_D_ACCESSACKDATA = 3'd1;

  localparam logic [TL_ADDR_BITS:0] MEM_BYTES = (TL_ADDR_BITS+1)'(MEM_WORDS * TL_DATA_BYTES);
  localparam logic [3:0]            LAT_INIT  = 4'(ACCESS_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t state_q, state_d;

  logic [3:0]               cnt_q;
  logic [2:0]               req_opcode;
  logic [IDX_W-1:0]         req_idx;
  logic [TL_DATA_BYTES-1:0] req_mask;
  logic [DATA_W-1:0]        req_data;
  logic                     req_deny;

  logic                     accept;
  logic                     do_access;

  logic [DATA_W-1:0]        mem [MEM_WORDS];

  // a_param carries no meaning for this slave.
  logic unused_a_param;
  assign unused_a_param = ^a_param;

  // ---------------------------------------------------------------------------
  // Request decode (evaluated on the incoming A beat, latched on accept)
  // ---------------------------------------------------------------------------
  // One extra bit on the subtraction: an address below BASE_ADDR wraps into the
  // top half, so a single unsigned compare covers both range limits.
  logic [TL_ADDR_BITS:0] a_offset;
  logic                  a_out_of_range;
  logic                  a_opcode_bad;
  logic                  a_size_bad;
  logic                  a_misaligned;
  logic                  a_deny;
  logic [IDX_W-1:0]      a_idx;

  assign a_offset       = {1'b0, a_address} - {1'b0, BASE_ADDR};
  assign a_out_of_range = (a_offset >= MEM_BYTES);
  assign a_opcode_bad   = !(a_opcode inside {TL_A_GET, TL_A_PUTFULL, TL_A_PUTPARTIAL});
  assign a_size_bad     = (a_size > TL_SIZE_BITS'(OFF_W));
  assign a_idx          = a_offset[OFF_W +: IDX_W];

  // Only the in-word offset bits can be misaligned once the size is legal.
  always_comb begin
    a_misaligned = 1'b0;
    for (int i = 0; i < int'(OFF_W); i++) begin
      if (i < int'(a_size) && a_address[i]) begin
        a_misaligned = 1'b1;
      end
    end
  end

  assign a_deny = a_out_of_range | a_opcode_bad | a_size_bad | a_misaligned;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_ready   = 1'b0;
    d_valid   = 1'b0;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        a_ready = !rst;
        accept  = a_valid && !rst;
        if (accept) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          do_access = !rst;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        d_valid = 1'b1;
        if (d_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, latency counter and registered D fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 4'd0;
      req_opcode <= 3'd0;
      req_idx    <= '0;
      req_mask   <= '0;
      req_data   <= '0;
      req_deny   <= 1'b0;
      d_opcode   <= TL_D_ACCESSACK;
      d_size     <= '0;
      d_source   <= '0;
      d_denied   <= 1'b0;
      d_data     <= '0;
    end else begin
      if (accept) begin
        cnt_q      <= LAT_INIT;
        req_opcode <= a_opcode;
        req_idx    <= a_idx;
        req_mask   <= a_mask;
        req_data   <= a_data;
        req_deny   <= a_deny;
        // Response opcode follows the request type even when denied.
        d_opcode   <= (a_opcode == TL_A_GET) ? TL_D_ACCESSACKDATA : TL_D_ACCESSACK;
        d_size     <= a_size;
        d_source   <= a_source;
        d_denied   <= a_deny;
      end else if (state_q == ST_ACCESS && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (do_access) begin
        d_data <= (req_opcode == TL_A_GET && !req_deny) ? mem[req_idx] : '0;
      end
    end
  end

  // RAM contents survive reset; do_access is already suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (do_access && !req_deny && req_opcode != TL_A_GET) begin
      for (int b = 0; b < int'(TL_DATA_BYTES); b++) begin
        if (req_opcode == TL_A_PUTFULL || req_mask[b]) begin
          mem[req_idx][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
  end

  assign d_param = 2'd0;
  assign d_sink  = SINK_ID;

endmodule
